// File: rtl/md_scheduler_if.sv
// md_scheduler_if: E-stage multiply/divide request bus and HI/LO result bus.
// The flush signal exists only when MD_FLUSH_EN is defined.
interface md_scheduler_if;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_val;
    logic        md_use_d;
`ifdef MD_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef MD_FLUSH_EN
    modport master (output start, md_op, rs_val, rt_val, mt_hi, mt_lo, mt_val, md_use_d, flush,
                    input  busy, stall, hi, lo);
    modport slave  (input  start, md_op, rs_val, rt_val, mt_hi, mt_lo, mt_val, md_use_d, flush,
                    output busy, stall, hi, lo);
`else
    modport master (output start, md_op, rs_val, rt_val, mt_hi, mt_lo, mt_val, md_use_d,
                    input  busy, stall, hi, lo);
    modport slave  (input  start, md_op, rs_val, rt_val, mt_hi, mt_lo, mt_val, md_use_d,
                    output busy, stall, hi, lo);
`endif
endinterface

// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle mult/multu/div/divu unit owning the HI/LO pair.
// Optional feature macro MD_FLUSH_EN adds a flush input that cancels an
// in-flight operation and discards same-cycle start/mt requests.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    md_scheduler_if.slave   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] L_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic        w_latch;

    // Datapath from the latched operands; only consumed on the final busy cycle.
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_neg_a, w_neg_b, w_div_zero;
    logic [31:0] w_mag_a, w_mag_b, w_div_b, w_q_mag, w_r_mag, w_quot, w_rem;

    assign w_prod_s   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
    // Signed divide works on magnitudes; op[0]=1 (divu) forces non-negative operands.
    assign w_neg_a    = r_a[31] & ~r_op[0];
    assign w_neg_b    = r_b[31] & ~r_op[0];
    assign w_mag_a    = w_neg_a ? -r_a : r_a;
    assign w_mag_b    = w_neg_b ? -r_b : r_b;
    assign w_div_zero = (r_b == 32'd0);
    // Substitute divisor keeps the divider defined; the result is discarded on /0.
    assign w_div_b    = w_div_zero ? 32'd1 : w_mag_b;
    assign w_q_mag    = w_mag_a / w_div_b;
    assign w_r_mag    = w_mag_a % w_div_b;
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, no negation.
    assign w_quot     = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
    assign w_rem      = w_neg_a ? -w_r_mag : w_r_mag;

    // Next-state, counter and HI/LO update decisions.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = bus.md_op[1] ? L_DIV : L_MULT;
                    w_state_nxt = BUSY;
                end else begin
                    if (bus.mt_hi) w_hi_nxt = bus.mt_val;
                    if (bus.mt_lo) w_lo_nxt = bus.mt_val;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                    if (!r_op[1]) begin
                        {w_hi_nxt, w_lo_nxt} = r_op[0] ? w_prod_u : w_prod_s;
                    end else if (!w_div_zero) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quot;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
`ifdef MD_FLUSH_EN
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
            w_latch     = 1'b0;
        end
`endif
    end

    // State, counter and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Operand capture on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= 2'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
        end else if (w_latch) begin
            r_op <= bus.md_op;
            r_a  <= bus.rs_val;
            r_b  <= bus.rt_val;
        end
    end

    assign bus.busy  = (r_state == BUSY);
    assign bus.stall = bus.md_use_d & ((r_state == BUSY) | bus.start);
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed bench with a HI/LO scoreboard for md_scheduler.
// Define MD_FLUSH_EN to also exercise the flush path.
module tb_md_scheduler;
    localparam int L_MULT = 5;
    localparam int L_DIV  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    md_scheduler_if bus ();

    md_scheduler #(.MULT_CYCLES(L_MULT), .DIV_CYCLES(L_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference model for one operation.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] oh, input logic [31:0] ol);
        exp_t        r;
        longint      p;
        logic [63:0] pu;
        int          q, rm;
        r.hi = oh;
        r.lo = ol;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            2'd2: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        r.lo = 32'h8000_0000;
                        r.hi = 32'd0;
                    end else begin
                        q  = $signed(a) / $signed(b);
                        rm = $signed(a) % $signed(b);
                        r.lo = q;
                        r.hi = rm;
                    end
                end
            end
            default: begin
                if (b != 32'd0) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Issue one operation and follow it to completion, checking every busy cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input logic mt_with_start, input logic mt_hi_busy,
                          input int exp_cycles);
        exp_t e;
        int   n;
        sb.push_back(model(op, a, b, m_hi, m_lo));
        bus.start    = 1'b1;
        bus.md_op    = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.md_use_d = use_d;
        bus.mt_lo    = mt_with_start;
        bus.mt_val   = 32'hDEAD_BEEF;
        #1;
        check("stall_start", {31'd0, bus.stall}, {31'd0, use_d});
        tick();
        bus.start = 1'b0;
        bus.mt_lo = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            bus.mt_hi  = mt_hi_busy && (n == 1);
            bus.mt_val = 32'hCAFE_F00D;
            #1;
            check("stall_busy", {31'd0, bus.stall}, {31'd0, use_d});
            check("hi_hold", bus.hi, m_hi);
            check("lo_hold", bus.lo, m_lo);
            tick();
            bus.mt_hi = 1'b0;
            n++;
        end
        check("busy_cycles", 32'(n), 32'(exp_cycles));
        check("stall_after", {31'd0, bus.stall}, 32'd0);
        e = sb.pop_front();
        check("hi_result", bus.hi, e.hi);
        check("lo_result", bus.lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
        bus.md_use_d = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.md_op    = 2'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.mt_hi    = 1'b0;
        bus.mt_lo    = 1'b0;
        bus.mt_val   = 32'd0;
        bus.md_use_d = 1'b0;
`ifdef MD_FLUSH_EN
        bus.flush    = 1'b0;
`endif
        tick();
        tick();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        reset = 1'b0;
        tick();

        // mult / multu
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0, L_MULT);
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, L_MULT);
        // div with the dependent instruction held in D; then divu by zero with mthi while busy
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, L_DIV);
        run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, L_DIV);

        // mtlo alone, then mthi+mtlo together
        bus.mt_lo  = 1'b1;
        bus.mt_val = 32'h1234_5678;
        tick();
        bus.mt_lo = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234_5678);
        check("mtlo_hi", bus.hi, m_hi);
        m_lo = 32'h1234_5678;
        bus.mt_hi  = 1'b1;
        bus.mt_lo  = 1'b1;
        bus.mt_val = 32'hA5A5_0F0F;
        tick();
        bus.mt_hi = 1'b0;
        bus.mt_lo = 1'b0;
        check("mtboth_hi", bus.hi, 32'hA5A5_0F0F);
        check("mtboth_lo", bus.lo, 32'hA5A5_0F0F);
        m_hi = 32'hA5A5_0F0F;
        m_lo = 32'hA5A5_0F0F;

        // start wins over same-cycle mtlo; signed overflow divide; plain divu
        run_op(2'd0, 32'd12345, 32'hFFFF_FF00, 1'b0, 1'b1, 1'b0, L_MULT);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, L_DIV);
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, L_DIV);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, L_DIV);

        // Reset during busy cycle 3 of a mult
        bus.start  = 1'b1;
        bus.md_op  = 2'd0;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        check("postrst_busy", {31'd0, bus.busy}, 32'd0);

`ifdef MD_FLUSH_EN
        // Give HI/LO non-zero contents, then flush in busy cycle 3
        bus.mt_hi  = 1'b1;
        bus.mt_lo  = 1'b1;
        bus.mt_val = 32'h0BAD_F00D;
        tick();
        bus.mt_hi = 1'b0;
        bus.mt_lo = 1'b0;
        m_hi = 32'h0BAD_F00D;
        m_lo = 32'h0BAD_F00D;
        bus.start  = 1'b1;
        bus.md_op  = 2'd1;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd9;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_hi", bus.hi, m_hi);
        check("flush_lo", bus.lo, m_lo);
        repeat (L_MULT) tick();
        check("flush_hi_late", bus.hi, m_hi);
        check("flush_lo_late", bus.lo, m_lo);
        // flush in IDLE discards start and mt
        bus.flush  = 1'b1;
        bus.start  = 1'b1;
        bus.mt_lo  = 1'b1;
        bus.mt_val = 32'h1111_2222;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.mt_lo = 1'b0;
        check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_idle_lo", bus.lo, m_lo);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
